// File: rtl/mem_access_stage_pkg.sv
// Shared widths, SRAM FSM states and address helper for the memory stage.
package mem_access_stage_pkg;

    localparam int ADDRESS_LEN   = 32;
    localparam int REGISTER_LEN  = 32;
    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;
    localparam int WORD_ADDR_LEN = 16;
    localparam int CNT_LEN       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    // Half-word address of one half of a word; the top address bit is always 0.
    function automatic logic [SRAM_ADDR_LEN-1:0] half_addr(
        input logic [WORD_ADDR_LEN-1:0] word,
        input logic                     hi
    );
        return {1'b0, word, hi};
    endfunction

endpackage

// File: rtl/mem_access_stage_sram_controller.sv
// Two-phase (low/high half-word) SRAM access FSM with registered bus drive.
module sram_controller
    import mem_access_stage_pkg::*;
#(
    parameter int SRAM_WAIT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd,
    input  logic                      wr,
    input  logic [WORD_ADDR_LEN-1:0]  word_addr,
    input  logic [REGISTER_LEN-1:0]   wdata,
    output logic                      ready,
    output logic [REGISTER_LEN-1:0]   rdata,
    output logic [SRAM_ADDR_LEN-1:0]  sram_addr,
    inout  wire  [SRAM_DATA_LEN-1:0]  sram_dq,
    output logic                      sram_we_n
);

    sram_state_e               state, state_n;
    logic [CNT_LEN-1:0]        cnt, cnt_n;
    logic                      last;
    logic                      latch_lo, latch_hi;
    logic                      in_phase_n, drive_n;
    logic                      dq_oe;
    logic [SRAM_DATA_LEN-1:0]  wdata_q;
    logic [SRAM_DATA_LEN-1:0]  data_lo, data_hi;

    assign last = (cnt == CNT_LEN'(SRAM_WAIT - 1));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        latch_lo = 1'b0;
        latch_hi = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd | wr) begin
                    state_n = ST_LO;
                    cnt_n   = '0;
                end
            end
            ST_LO: begin
                if (last) begin
                    state_n  = ST_HI;
                    cnt_n    = '0;
                    latch_lo = rd;
                end else begin
                    cnt_n = cnt + CNT_LEN'(1);
                end
            end
            ST_HI: begin
                if (last) begin
                    state_n  = ST_DONE;
                    cnt_n    = '0;
                    latch_hi = rd;
                end else begin
                    cnt_n = cnt + CNT_LEN'(1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign in_phase_n = (state_n == ST_LO) || (state_n == ST_HI);
    assign drive_n    = wr & in_phase_n;

    // Bus controls are registered from the next state so they only move on edges
    // and stay constant across a whole phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sram_we_n <= 1'b1;
            dq_oe     <= 1'b0;
            sram_addr <= '0;
            wdata_q   <= '0;
            data_lo   <= '0;
            data_hi   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sram_we_n <= ~drive_n;
            dq_oe     <= drive_n;
            if (in_phase_n) begin
                sram_addr <= half_addr(word_addr, state_n == ST_HI);
                wdata_q   <= (state_n == ST_HI) ? wdata[31:16] : wdata[15:0];
            end
            if (latch_lo) data_lo <= sram_dq;
            if (latch_hi) data_hi <= sram_dq;
        end
    end

    assign sram_dq = dq_oe ? wdata_q : {SRAM_DATA_LEN{1'bz}};
    assign rdata   = {data_hi, data_lo};
    // Held in reset the stage must not stall, whatever the inputs are.
    assign ready   = ~rst | (state == ST_DONE);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: SRAM word access via sram_controller plus the MEM/WB pipeline register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int ADDR_BASE = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDRESS_LEN-1:0]    pc_in,
    input  logic                      wb_en_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic [3:0]                dest_in,
    input  logic [REGISTER_LEN-1:0]   alu_res_in,
    input  logic [REGISTER_LEN-1:0]   val_rm_in,
    output logic                      freeze,
    output logic [ADDRESS_LEN-1:0]    pc_out,
    output logic                      wb_en_out,
    output logic                      mem_read_out,
    output logic [3:0]                dest_out,
    output logic [REGISTER_LEN-1:0]   alu_res_out,
    output logic [REGISTER_LEN-1:0]   data_mem_out,
    output logic [SRAM_ADDR_LEN-1:0]  sram_addr,
    inout  wire  [SRAM_DATA_LEN-1:0]  sram_dq,
    output logic                      sram_we_n
);

    logic                      ready;
    logic [WORD_ADDR_LEN-1:0]  word_addr;
    logic [REGISTER_LEN-1:0]   rdata;

    // Only bits [17:2] of (alu_res_in - ADDR_BASE) matter; the low 18 bits of the
    // difference depend only on the low 18 bits of the operands.
    assign word_addr = WORD_ADDR_LEN'((alu_res_in[17:0] - 18'(ADDR_BASE)) >> 2);

    sram_controller #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_sram (
        .clk       (clk),
        .rst       (rst),
        .rd        (mem_read_in & ~mem_write_in),
        .wr        (mem_write_in),
        .word_addr (word_addr),
        .wdata     (val_rm_in),
        .ready     (ready),
        .rdata     (rdata),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_we_n (sram_we_n)
    );

    assign freeze = (mem_read_in | mem_write_in) & ~ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out       <= '0;
            wb_en_out    <= 1'b0;
            mem_read_out <= 1'b0;
            dest_out     <= '0;
            alu_res_out  <= '0;
            data_mem_out <= '0;
        end else if (!freeze) begin
            pc_out       <= pc_in;
            wb_en_out    <= wb_en_in;
            mem_read_out <= mem_read_in;
            dest_out     <= dest_in;
            alu_res_out  <= alu_res_in;
            data_mem_out <= rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: SRAM model, word-level reference model, vector table and random ops.
module tb_mem_access_stage;

    localparam int W    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        wb_en_in, mem_read_in, mem_write_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_res_in, val_rm_in;
    logic        freeze;
    logic [31:0] pc_out;
    logic        wb_en_out, mem_read_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_res_out, data_mem_out;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;

    always #5 clk = ~clk;

    mem_access_stage #(.SRAM_WAIT(W), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en_in(wb_en_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .dest_in(dest_in),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .freeze(freeze),
        .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
        .dest_out(dest_out), .alu_res_out(alu_res_out), .data_mem_out(data_mem_out),
        .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_we_n(sram_we_n)
    );

    // Half-word SRAM: drives the bus while a non-write access is stalling the pipe.
    logic [15:0] sram [0:262143];
    assign sram_dq = (sram_we_n && freeze) ? sram[sram_addr] : 16'hzzzz;
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq;

    // Reference: memory as 32-bit words, plus the last loaded word.
    logic [31:0] wmem [int];
    logic [31:0] last_load;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wb, mr, mw;
        logic [3:0]  dest;
        logic [31:0] pc, alu, val;
        int          exp_frz;
        logic [31:0] exp_data;
        logic        exp_mr;
    } vec_t;

    task automatic run(input vec_t v, output int frz);
        logic [31:0] addr;
        logic [15:0] word;
        logic        is_mem, bus_ok;
        @(negedge clk);
        wb_en_in = v.wb; mem_read_in = v.mr; mem_write_in = v.mw;
        dest_in = v.dest; pc_in = v.pc; alu_res_in = v.alu; val_rm_in = v.val;
        #1;
        addr   = v.alu - BASE;
        word   = addr[17:2];
        is_mem = v.mr | v.mw;
        bus_ok = 1'b1;
        frz    = 0;
        while (freeze && frz < 100) begin
            frz++;
            @(negedge clk); #1;
            if (freeze) begin
                if (sram_addr !== {1'b0, word, (frz > W)}) bus_ok = 1'b0;
                if (v.mw) begin
                    if (sram_we_n !== 1'b0) bus_ok = 1'b0;
                    if (sram_dq !== ((frz > W) ? v.val[31:16] : v.val[15:0])) bus_ok = 1'b0;
                end else if (sram_we_n !== 1'b1) bus_ok = 1'b0;
            end
        end
        if (is_mem) chk("bus_phases", 32'(bus_ok), 32'd1);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("freeze_cycles", frz, is_mem ? 2 * W + 1 : 0);
        if (v.mw) wmem[int'(word)] = v.val;
        else if (v.mr) last_load = wmem.exists(int'(word)) ? wmem[int'(word)] : 32'h0;
        @(posedge clk); #1;
        chk("alu_res_out", alu_res_out, v.alu);
        chk("dest_out", 32'(dest_out), 32'(v.dest));
        chk("wb_en_out", 32'(wb_en_out), 32'(v.wb));
        chk("mem_read_out", 32'(mem_read_out), 32'(v.mr));
        chk("pc_out", pc_out, v.pc);
        chk("data_mem_out", data_mem_out, last_load);
    endtask

    vec_t tbl [10];
    vec_t rv;
    int   frz;

    function automatic vec_t mk(input logic wb, mr, mw, input logic [3:0] dest,
                                input logic [31:0] alu, val, input int ef,
                                input logic [31:0] ed, input logic em);
        vec_t v;
        v.wb = wb; v.mr = mr; v.mw = mw; v.dest = dest; v.pc = $urandom;
        v.alu = alu; v.val = val; v.exp_frz = ef; v.exp_data = ed; v.exp_mr = em;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
        last_load = 32'h0;

        tbl[0] = mk(1, 0, 0, 3, 32'h5,        32'h0,        0, 32'h0,        0);
        tbl[1] = mk(0, 0, 1, 0, BASE + 8,     32'hDEADBEEF, 5, 32'h0,        0);
        tbl[2] = mk(1, 1, 0, 1, BASE + 8,     32'h0,        5, 32'hDEADBEEF, 1);
        tbl[3] = mk(1, 1, 0, 2, BASE + 8,     32'h0,        5, 32'hDEADBEEF, 1);
        tbl[4] = mk(0, 0, 1, 0, BASE + 12,    32'h12345678, 5, 32'hDEADBEEF, 0);
        tbl[5] = mk(1, 1, 0, 4, BASE + 15,    32'h0,        5, 32'h12345678, 1);
        tbl[6] = mk(0, 1, 1, 0, BASE + 16,    32'hCAFEF00D, 5, 32'h12345678, 1);
        tbl[7] = mk(1, 1, 0, 5, BASE + 16,    32'h0,        5, 32'hCAFEF00D, 1);
        tbl[8] = mk(1, 0, 0, 6, BASE + 16,    32'h0,        0, 32'hCAFEF00D, 0);
        tbl[9] = mk(1, 1, 0, 7, BASE - 4,     32'h0,        5, 32'h0,        1);

        // Reset held with random inputs.
        rst = 1'b0;
        wb_en_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1; dest_in = 4'hF;
        pc_in = $urandom; alu_res_in = $urandom; val_rm_in = $urandom;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_outs", {pc_out | alu_res_out | data_mem_out}, 32'd0);
        chk("rst_flags", 32'({wb_en_out, mem_read_out, dest_out}), 32'd0);
        mem_read_in = 1'b0; mem_write_in = 1'b0;
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run(tbl[i], frz);
            chk("tbl_freeze", frz, tbl[i].exp_frz);
            chk("tbl_data", data_mem_out, tbl[i].exp_data);
            chk("tbl_mem_read", 32'(mem_read_out), 32'(tbl[i].exp_mr));
        end

        // Reset asserted during the HI phase of a store to an otherwise unused word.
        @(negedge clk);
        wb_en_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b1; dest_in = 4'h0;
        alu_res_in = BASE + 160; val_rm_in = 32'hA5A55A5A;
        repeat (W + 1) @(negedge clk);
        #1;
        chk("hi_addr", 32'(sram_addr), 32'd81);
        chk("hi_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_freeze", 32'(freeze), 32'd0);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_dq_z", 32'(sram_dq === 16'hzzzz), 32'd1);
        chk("abort_outs", alu_res_out | data_mem_out, 32'd0);
        mem_write_in = 1'b0;
        @(negedge clk); rst = 1'b1;
        last_load = 32'h0;
        run(mk(1, 1, 0, 9, BASE + 8, 32'h0, 5, 32'h0, 1), frz);
        chk("post_rst_load", data_mem_out, 32'hDEADBEEF);

        // Random back-to-back mix over a small set of words.
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 3);
            rv = mk(1'($urandom), op == 1 || op == 3, op >= 2, 4'($urandom),
                    $urandom, $urandom, 0, 32'h0, 0);
            if (op != 0) rv.alu = BASE + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
            run(rv, frz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage ARM pipeline, directly upstream of the write-back stage. It performs LDR/STR accesses to the board's external 16-bit SRAM as two half-word transactions. While an access is in flight it stalls the pipeline through `freeze`. It also holds the MEM/WB pipeline register, so write-back receives registered `mem_read`, ALU result, loaded data, destination and PC.

## Interface
- `SRAM_WAIT`, default 2: cycles each half-word SRAM transaction is held; legal range 1–15.
- `ADDR_BASE`, default 1024: byte offset subtracted from the ALU result to form the data address.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset, asynchronous and active-low.
- `pc_in` in `ADDRESS_LEN`: PC of the instruction in MEM.
- `wb_en_in` in 1: register write enable.
- `mem_read_in` in 1: LDR.
- `mem_write_in` in 1: STR.
- `dest_in` in 4: destination register.
- `alu_res_in` in `REGISTER_LEN`: ALU result, or byte address for loads and stores.
- `val_rm_in` in `REGISTER_LEN`: store data.
- `freeze` out 1: stalls IF, ID, EX and the EX/MEM register.
- `pc_out` out `ADDRESS_LEN`: registered PC.
- `wb_en_out` out 1: registered write enable.
- `mem_read_out` out 1: registered load flag.
- `dest_out` out 4: registered destination.
- `alu_res_out` out `REGISTER_LEN`: registered ALU result.
- `data_mem_out` out `REGISTER_LEN`: registered load data.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq` inout 16: SRAM data bus.
- `sram_we_n` out 1: SRAM write enable, active-low.

## Operation
- Address calculation:
  - `addr = alu_res_in - ADDR_BASE`, computed modulo 2^32.
  - Low half-word address: `sram_addr = {addr[17:2], 1'b0}`. High half-word address: `{addr[17:2], 1'b1}`.
  - `addr[1:0]` is ignored; every access is word-aligned.
- FSM states: IDLE, LO, HI, DONE. A wait counter runs 0..SRAM_WAIT-1.
  - IDLE:
    - If `mem_read_in | mem_write_in`, go to LO, clear the counter, assert `freeze`.
    - Otherwise stay in IDLE with `freeze=0`.
  - LO:
    - Drive the low-half address.
    - On write, drive `val_rm_in[15:0]` onto `sram_dq` and hold `sram_we_n=0`.
    - On read, tri-state `sram_dq` and, on the last counter cycle, latch `sram_dq` into `data_lo`.
    - After SRAM_WAIT cycles, go to HI.
  - HI: same as LO using the high-half address and `val_rm_in[31:16]`. On read, latch into `data_hi`. After SRAM_WAIT cycles, go to DONE.
  - DONE: `freeze=0`, `sram_we_n=1`, bus tri-stated. Next state is IDLE unconditionally.
- `freeze` equals `(state==IDLE & (mem_read_in|mem_write_in)) | state==LO | state==HI`.
- MEM/WB register:
  - Loads all outputs on every rising edge where `freeze==0`.
  - `data_mem_out` loads `{data_hi, data_lo}`.
  - All other outputs load the corresponding `_in` value.
- A request with both `mem_read_in` and `mem_write_in` set is treated as a write.
- Inputs are stable while `freeze=1`, because upstream is frozen. The block does not re-sample them.

## Timing
- Reset: all outputs, `data_lo`, `data_hi` and the counter are 0; the state is IDLE; `sram_we_n=1`; `sram_dq` is tri-stated.
- Reset applied mid-access aborts the access immediately. A partially written word is permitted; there is no rollback.
- Non-memory instruction: `freeze=0`, and outputs update at the next edge (1-cycle latency).
- Memory instruction:
  - `freeze` is high for `2*SRAM_WAIT+1` consecutive cycles: one IDLE cycle, SRAM_WAIT LO cycles, SRAM_WAIT HI cycles.
  - In the DONE cycle `freeze` is low, and the MEM/WB register captures at the end of DONE.
  - With SRAM_WAIT=2 this is 5 stall cycles; outputs are valid 6 cycles after the request is first seen.
- Back-to-back memory instructions: DONE→IDLE, then the next request is seen in IDLE on the following cycle. There are no idle bus cycles beyond DONE.
- `sram_we_n` changes only on clock edges. Address and data are stable for the whole of each phase.

## Structure
- Shared `defines.v` supplies `ADDRESS_LEN` and `REGISTER_LEN`. Add `SRAM_ADDR_LEN` (18) and `SRAM_DATA_LEN` (16) to it.
- Local FSM state encodings are localparams.
- One sub-module, `sram_controller`, holds the FSM, counter, bus drive and `data_lo`/`data_hi`, and exports `ready`. `mem_access_stage` wraps it together with the MEM/WB register, with `freeze` defined as `(mem_read_in|mem_write_in) & ~ready`.

## Test plan
- Reset held low with random inputs → all outputs 0, `freeze=0`, `sram_we_n=1`, `sram_dq` high-Z.
- ADD with `alu_res_in=32'h0000_0005`, `dest_in=3`, `wb_en_in=1` → `freeze` stays 0; next edge gives `alu_res_out=5`, `dest_out=3`, `mem_read_out=0`.
- STR with `alu_res_in=1024+8`, `val_rm_in=32'hDEAD_BEEF`, SRAM_WAIT=2:
  - `freeze` is high for 5 cycles.
  - `sram_addr=4`, data `16'hBEEF`, `we_n` low for 2 cycles.
  - Then `sram_addr=5`, data `16'hDEAD` for 2 cycles.
- LDR from the same address → `freeze` high for 5 cycles; after DONE, `data_mem_out=32'hDEAD_BEEF` and `mem_read_out=1`.
- LDR followed immediately by STR → the two accesses are separated only by the DONE cycle plus the next IDLE cycle, and the first load's data is correct.
- `rst` driven low during the HI phase of a store → state returns to IDLE at once, `sram_we_n=1`, `freeze=0`; after release, a new LDR completes normally.
